// File: rtl/seq101_scan_ctrl.sv
// seq101_scan_ctrl: serially scans a W-bit word, MSB first, for the pattern
// "101" (overlapping). Reports whether a match was seen, how many, and the
// bit index of the first match. In mode 0 the scan stops at the first match.
module seq101_scan_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] data_in,
    input  logic         mode,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [3:0]   count,
    output logic [3:0]   first_pos
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {D0, D1, D10} det_t;

    localparam logic [3:0] LAST_IDX  = 4'(W - 1);
    localparam logic [3:0] COUNT_MAX = 4'hF;

    state_t       state;
    state_t       state_next;
    det_t         det;
    det_t         det_next;
    logic [W-1:0] shreg;
    logic         mode_q;
    logic [3:0]   bit_cnt;
    logic         bit_in;
    logic         match;
    logic         last_bit;

    assign bit_in   = shreg[W-1];
    assign last_bit = (bit_cnt == LAST_IDX);
    // A match is the final "1" arriving while the detector holds "10".
    assign match    = (state == SHIFT) && (det == D10) && bit_in;

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller next state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit || (match && !mode_q)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Detector next state; a trailing "1" of a match seeds the next one.
    always_comb begin
        det_next = det;
        case (det)
            D0:      det_next = bit_in ? D1 : D0;
            D1:      det_next = bit_in ? D1 : D10;
            D10:     det_next = bit_in ? D1 : D0;
            default: det_next = D0;
        endcase
    end

    // Scan datapath: load on accepted start, shift and tally during SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det       <= D0;
            shreg     <= '0;
            mode_q    <= 1'b0;
            bit_cnt   <= '0;
            found     <= 1'b0;
            count     <= '0;
            first_pos <= '0;
        end else if (state == IDLE && start) begin
            det       <= D0;
            shreg     <= data_in;
            mode_q    <= mode;
            bit_cnt   <= '0;
            found     <= 1'b0;
            count     <= '0;
            first_pos <= '0;
        end else if (state == SHIFT) begin
            det     <= det_next;
            shreg   <= {shreg[W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            if (match) begin
                if (count != COUNT_MAX) begin
                    count <= count + 4'd1;
                end
                if (!found) begin
                    found     <= 1'b1;
                    first_pos <= bit_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq101_scan_ctrl.sv
// Scoreboard bench for seq101_scan_ctrl (W=8). Stimulus pushes expected
// results with the expected done edge; a monitor pops on every done pulse.
module tb_seq101_scan_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] data_in;
    logic         mode;
    logic         busy;
    logic         done;
    logic         found;
    logic [3:0]   count;
    logic [3:0]   first_pos;

    typedef struct {
        int         t_done;
        logic       found;
        logic [3:0] count;
        logic [3:0] fp;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    seq101_scan_ctrl #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .count     (count),
        .first_pos (first_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.t_done);
                chk("found", int'(found), int'(e.found));
                chk("count", int'(count), int'(e.count));
                chk("first_pos", int'(first_pos), int'(e.fp));
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic push_exp(input int t_done, input logic f, input logic [3:0] c,
                            input logic [3:0] p);
        exp_t e;
        e.t_done = t_done;
        e.found  = f;
        e.count  = c;
        e.fp     = p;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    // One scan; lat = edges from the accepting edge to the edge raising done.
    task automatic run_scan(input logic [W-1:0] d, input logic m, input logic ef,
                            input logic [3:0] ec, input logic [3:0] efp, input int lat);
        @(negedge clk);
        data_in = d;
        mode    = m;
        start   = 1'b1;
        push_exp(cyc + 1 + lat, ef, ec, efp);
        @(negedge clk);
        start   = 1'b0;
        data_in = ~d;
        mode    = ~m;
        wait_empty(40);
        repeat (2) @(negedge clk);
        chk("hold_found", int'(found), int'(ef));
        chk("hold_count", int'(count), int'(ec));
        chk("hold_first_pos", int'(first_pos), int'(efp));
    endtask

    initial begin
        int t0;
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        mode    = 1'b0;

        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_first_pos", int'(first_pos), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors: data, mode, found, count, first_pos, latency.
        run_scan(8'b10100000, 1'b1, 1'b1, 4'd1, 4'd2, 8);
        run_scan(8'b10101010, 1'b1, 1'b1, 4'd3, 4'd2, 8);
        run_scan(8'b10101010, 1'b0, 1'b1, 4'd1, 4'd2, 3);
        run_scan(8'b11001100, 1'b1, 1'b0, 4'd0, 4'd0, 8);
        run_scan(8'b00000101, 1'b0, 1'b1, 4'd1, 4'd7, 8);
        run_scan(8'b11111111, 1'b1, 1'b0, 4'd0, 4'd0, 8);
        run_scan(8'b01011011, 1'b1, 1'b1, 4'd2, 4'd3, 8);
        run_scan(8'b10110101, 1'b0, 1'b1, 4'd1, 4'd2, 3);

        // Asynchronous reset mid-scan: no done, outputs cleared at once.
        @(negedge clk);
        data_in = 8'b10100000;
        mode    = 1'b1;
        start   = 1'b1;
        t0      = cyc + 1;
        @(negedge clk);
        start   = 1'b0;
        while (cyc < t0 + 3) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_found", int'(found), 1);
        chk("pre_rst_count", int'(count), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_found", int'(found), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_first_pos", int'(first_pos), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        run_scan(8'b00000101, 1'b1, 1'b1, 4'd1, 4'd7, 8);

        // Starts during SHIFT and during DONE are ignored.
        @(negedge clk);
        data_in = 8'b10101010;
        mode    = 1'b1;
        start   = 1'b1;
        t0      = cyc + 1;
        push_exp(t0 + 8, 1'b1, 4'd3, 4'd2);
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'b00000000;
        while (cyc < t0 + 1) @(negedge clk);
        start   = 1'b1;
        data_in = 8'b11111111;
        mode    = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        chk("done_state_before_ignored_start", int'(done), 1);
        start   = 1'b1;
        data_in = 8'b01010000;
        mode    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_empty(5);
        repeat (15) @(negedge clk);
        chk("ignored_found", int'(found), 1);
        chk("ignored_count", int'(count), 3);
        chk("ignored_first_pos", int'(first_pos), 2);

        // start held high: a new scan every W+2 cycles.
        @(negedge clk);
        data_in = 8'b10100000;
        mode    = 1'b1;
        start   = 1'b1;
        t0      = cyc + 1;
        push_exp(t0 + 8, 1'b1, 4'd1, 4'd2);
        push_exp(t0 + 18, 1'b1, 4'd1, 4'd2);
        push_exp(t0 + 28, 1'b1, 4'd1, 4'd2);
        while (cyc < t0 + 20) @(negedge clk);
        start = 1'b0;
        wait_empty(40);
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule
